// File: rtl/mem_stage.sv
// Memory stage: retires ALU results to writeback and runs loads/stores over a
// req/ack data-memory port, stalling upstream while a transaction is outstanding.
module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [73:0] exbus,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [37:0] wbbus,
  output logic [4:0]  mem_dst,
  output logic [32:0] mem_bypass,
  output logic        mem_err
);

  localparam int unsigned CNT_W    = 16;
  localparam logic [3:0]  OP_LOAD  = 4'b1000;
  localparam logic [3:0]  OP_STORE = 4'b1001;

  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [4:0]  dst;
    logic [31:0] res;
    logic [31:0] stval;
  } ex_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  dst;
    logic [31:0] data;
  } wb_t;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  ex_t              ex;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [4:0]       lat_dst, lat_dst_n;
  logic             lat_load, lat_load_n;
  wb_t              wb, wb_n;
  logic             req_n, we_n, err_n;
  logic [31:0]      addr_n, wdata_n;
  logic             is_alu, is_mem;

  assign ex     = ex_t'(exbus);
  assign is_alu = ex.valid && (ex.op >= 4'd1) && (ex.op <= 4'd7);
  assign is_mem = ex.valid && ((ex.op == OP_LOAD) || (ex.op == OP_STORE));

  assign mem_stall = (state == S_WAIT);
  assign wbbus     = wb;

  // Next-state and next-output logic
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    lat_dst_n  = lat_dst;
    lat_load_n = lat_load;
    wb_n       = '{valid: 1'b0, dst: wb.dst, data: wb.data};
    req_n      = dmem_req;
    we_n       = dmem_we;
    addr_n     = dmem_addr;
    wdata_n    = dmem_wdata;
    err_n      = mem_err;
    case (state)
      S_IDLE: begin
        if (is_alu) begin
          wb_n = '{valid: 1'b1, dst: ex.dst, data: ex.res};
        end else if (is_mem) begin
          if (ex.res[1:0] != 2'b00) begin
            err_n = 1'b1;
          end else begin
            lat_dst_n  = ex.dst;
            lat_load_n = (ex.op == OP_LOAD);
            addr_n     = ex.res;
            wdata_n    = ex.stval;
            we_n       = (ex.op == OP_STORE);
            req_n      = 1'b1;
            cnt_n      = '0;
            state_n    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // Ack takes priority over an expiring timeout on the same edge
        if (dmem_ack) begin
          req_n   = 1'b0;
          state_n = S_IDLE;
          if (lat_load) begin
            wb_n = '{valid: 1'b1, dst: lat_dst, data: dmem_rdata};
          end
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          req_n   = 1'b0;
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Hazard-control view of the instruction held in this stage
  always_comb begin
    mem_dst    = 5'd0;
    mem_bypass = 33'd0;
    if (state == S_WAIT) begin
      if (lat_load) mem_dst = lat_dst;
    end else begin
      if (is_alu || (ex.valid && ex.op == OP_LOAD)) mem_dst = ex.dst;
      if (is_alu) mem_bypass = {1'b1, ex.res};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      lat_dst    <= '0;
      lat_load   <= 1'b0;
      wb         <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      mem_err    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      lat_dst    <= lat_dst_n;
      lat_load   <= lat_load_n;
      wb         <= wb_n;
      dmem_req   <= req_n;
      dmem_we    <= we_n;
      dmem_addr  <= addr_n;
      dmem_wdata <= wdata_n;
      mem_err    <= err_n;
    end
  end

endmodule
